video_timing_ctrl: RTL
======================

Name: video_timing_ctrl

Overview:
Raster sequencer that drives pattern and pixel generators: scans h/v counters through active, front porch, sync and back porch. Outputs pixel coordinates x/y, a data-enable, sync pulses and a frame-start strobe. Also synchronizes the user button and presents it frame-stable to downstream pattern logic. Sits between the pixel clock domain root and the per-pixel colour generators / video encoder.

Parameters:
HOR_ACTIVE_PIXELS, 640, visible pixels per line
HOR_FRONT_PORCH, 16, pixels
HOR_SYNC, 96, pixels
HOR_BACK_PORCH, 48, pixels
VER_ACTIVE_PIXELS, 480, visible lines
VER_FRONT_PORCH, 10, lines
VER_SYNC, 2, lines
VER_BACK_PORCH, 33, lines
HSYNC_POL, 0, active level of hsync (1 = high)
VSYNC_POL, 0, active level of vsync (1 = high)

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous, active-high reset
btn  input  1  raw asynchronous button
x  output  $clog2(HOR_ACTIVE_PIXELS)  pixel column, valid when de=1
y  output  $clog2(VER_ACTIVE_PIXELS)  pixel row, valid when de=1
de  output  1  active-video enable
hsync  output  1  horizontal sync, polarity HSYNC_POL
vsync  output  1  vertical sync, polarity VSYNC_POL
frame_start  output  1  one-cycle strobe at position (0,0)
btn_frame  output  1  synchronized button, frame-stable
frame_cnt  output  8  frame counter, wraps

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- H_TOTAL = sum of HOR_*; V_TOTAL = sum of VER_*. Internal h_cnt width $clog2(H_TOTAL), v_cnt width $clog2(V_TOTAL).
- h_cnt increments every cycle and wraps H_TOTAL-1 -> 0. On wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- Region order per axis, counted from 0: active [0, ACTIVE), front porch, sync, back porch.
- Outputs are registered decodes of the counter state, with 1 cycle latency behind the counters.
  - de = h_act & v_act.
  - x = h_cnt when h_act, else 0; y = v_cnt when v_act, else 0. Both are truncated to port width.
  - hsync = HSYNC_POL while h_cnt is in the horizontal sync region, else ~HSYNC_POL.
  - vsync = VSYNC_POL for every cycle of the lines whose v_cnt is in the vertical sync region. It changes at line start, aligned with h_cnt = 0.
  - frame_start = 1 only for decode of (0,0).
- Reset:
  - Counters go to (0,0).
  - Outputs go to x=0, y=0, de=0, frame_start=0, btn_frame=0, frame_cnt=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - First cycle after rst deasserts: outputs show (0,0), de=1, frame_start=1.
  - Reset mid-frame restarts the raster identically; no partial-frame state survives.
- frame_cnt increments in the cycle frame_start is output, but not on the first frame after reset, so frame 0 reads 0. Wraps 255 -> 0.
- btn passes through a 2-flop synchronizer (btn_s) before any use.
- Simultaneous events: the end-of-line wrap and end-of-frame wrap resolve in the same cycle. The next output decode is (0,0).
- Parameter legality (elaboration check): every porch and sync value >= 1, and every ACTIVE >= 2.

Optional Feature:
Macro VIDEO_TIMING_BTN_LATCH_EN.
- Defined: btn_frame samples btn_s only in the cycle frame_start is asserted and holds for the whole frame, so patterns never tear mid-frame.
- Undefined: btn_frame = btn_s, i.e. 2-cycle synchronizer latency with no frame alignment.

Decomposition:
- Package video_pkg: region enum (ACTIVE, FRONT, SYNC, BACK), H_TOTAL/V_TOTAL constant functions, counter width helpers.
- One sub-module, video_axis_counter, instantiated once per axis. It has parameters ACTIVE/FP/SYNC/BP and ports clk, rst, en, cnt, region, wrap.
- The top level chains h.wrap into v.en and registers the outputs.

Test Plan:
Use small config HOR 4/1/2/1 (H_TOTAL=8), VER 3/1/1/1 (V_TOTAL=6), HSYNC_POL=0, VSYNC_POL=1; one frame = 48 cycles.
1. Reset held 3 cycles, then released -> during reset: de=0, hsync=1, vsync=0, frame_start=0. First released cycle: x=0, y=0, de=1, frame_start=1.
2. Line 0 scan -> de=1 for cycles 0..3 with x=0,1,2,3; de=0 for cycles 4..7; hsync=0 exactly in cycles 5 and 6.
3. Full frame -> vsync=1 for cycles 32..39 (line 4). frame_start recurs at cycle 48. frame_cnt reads 1 from cycle 48 and 255 -> 0 after 256 frames.
4. Assert rst at cycle 20 for 1 cycle -> outputs idle for 1 cycle, then (0,0) with frame_start=1; frame_cnt=0.
5. Macro undefined: btn 0 -> 1 at cycle 10 -> btn_frame=1 two cycles later.
6. Macro defined: same stimulus -> btn_frame stays 0 until the frame_start at cycle 48, then 1. A btn pulse fully inside cycles 49..90 is never reflected.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and sizing helpers for the video raster timing block.
package video_pkg;

  typedef enum logic [1:0] {
    RGN_ACTIVE = 2'd0,
    RGN_FRONT  = 2'd1,
    RGN_SYNC   = 2'd2,
    RGN_BACK   = 2'd3
  } region_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: free-running position counter plus region decode.
// Used once per axis; the vertical instance is enabled by the horizontal wrap.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int ACTIVE = 4,
  parameter int FP     = 1,
  parameter int SYNC   = 2,
  parameter int BP     = 1,
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int W     = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output region_e      region,
  output logic         wrap
);

  localparam logic [W-1:0] FP_START   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  generate
    if (ACTIVE < 2 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
      $error("video_axis_counter: ACTIVE must be >= 2 and FP/SYNC/BP >= 1");
    end
  endgenerate

  always_comb begin
    wrap = en && (cnt_q == LAST);
    if (!en) begin
      cnt_d = cnt_q;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_comb begin
    if (cnt_q < FP_START) begin
      region = RGN_ACTIVE;
    end else if (cnt_q < SYNC_START) begin
      region = RGN_FRONT;
    end else if (cnt_q < BP_START) begin
      region = RGN_SYNC;
    end else begin
      region = RGN_BACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: registered x/y/de/sync/frame strobes from h/v counters.
// Optional macro VIDEO_TIMING_BTN_LATCH_EN latches the button once per frame.
module video_timing_ctrl
  import video_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int HOR_FRONT_PORCH   = 16,
  parameter int HOR_SYNC          = 96,
  parameter int HOR_BACK_PORCH    = 48,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int VER_FRONT_PORCH   = 10,
  parameter int VER_SYNC          = 2,
  parameter int VER_BACK_PORCH    = 33,
  parameter int HSYNC_POL         = 0,
  parameter int VSYNC_POL         = 0,
  localparam int XW = $clog2(HOR_ACTIVE_PIXELS),
  localparam int YW = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          btn_frame,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = axis_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC, HOR_BACK_PORCH);
  localparam int V_TOTAL = axis_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC, VER_BACK_PORCH);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam logic HS_ACT = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ACT = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  region_e       h_region, v_region;
  logic          h_wrap, v_wrap;

  video_axis_counter #(
    .ACTIVE(HOR_ACTIVE_PIXELS), .FP(HOR_FRONT_PORCH), .SYNC(HOR_SYNC), .BP(HOR_BACK_PORCH)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(h_cnt), .region(h_region), .wrap(h_wrap)
  );

  video_axis_counter #(
    .ACTIVE(VER_ACTIVE_PIXELS), .FP(VER_FRONT_PORCH), .SYNC(VER_SYNC), .BP(VER_BACK_PORCH)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap), .cnt(v_cnt), .region(v_region), .wrap(v_wrap)
  );

  // Counters only reach (0,0) through reset or a joint line/frame wrap.
  logic at_origin_q, at_origin_d;
  logic first_frame_q, first_frame_d;
  logic btn_meta_q, btn_s_q;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  always_comb begin
    at_origin_d   = h_wrap && v_wrap;
    x_d           = (h_region == RGN_ACTIVE) ? XW'(h_cnt) : '0;
    y_d           = (v_region == RGN_ACTIVE) ? YW'(v_cnt) : '0;
    de_d          = (h_region == RGN_ACTIVE) && (v_region == RGN_ACTIVE);
    hsync_d       = (h_region == RGN_SYNC) ? HS_ACT : ~HS_ACT;
    vsync_d       = (v_region == RGN_SYNC) ? VS_ACT : ~VS_ACT;
    fs_d          = at_origin_q;
    first_frame_d = at_origin_q ? 1'b0 : first_frame_q;
    if (at_origin_q && !first_frame_q) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin_q   <= 1'b1;
      first_frame_q <= 1'b1;
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      fs_q          <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      at_origin_q   <= at_origin_d;
      first_frame_q <= first_frame_d;
      btn_meta_q    <= btn;
      btn_s_q       <= btn_meta_q;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      fs_q          <= fs_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef VIDEO_TIMING_BTN_LATCH_EN
  logic btn_frame_q, btn_frame_d;

  always_comb begin
    btn_frame_d = at_origin_q ? btn_s_q : btn_frame_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_frame_q <= 1'b0;
    end else begin
      btn_frame_q <= btn_frame_d;
    end
  end

  assign btn_frame = btn_frame_q;
`else
  assign btn_frame = btn_s_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
